// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory request bus between the multi-cycle controller and memory.
// The controller drives the request side; memory answers with a ready strobe.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences one instruction over several cycles, drives datapath
// selects/enables and the shared memory port, and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [5:0]           opcode_i,
  input  logic [5:0]           funct_i,
  input  logic                 zero_i,
  multicycle_ctrl_if.master    mem_io,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic [1:0]           pc_source_o,
  output logic                 reg_write_o,
  output logic [1:0]           reg_dst_o,
  output logic [1:0]           mem_to_reg_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [2:0]           alu_op_o,
  output logic [3:0]           state_o,
  output logic                 illegal_o,
  output logic [CNT_W-1:0]     instr_cnt_o
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnJr    = 6'h08;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StRWb     = 4'd7,
    StExecI   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StJr      = 4'd12,
    StTrap    = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d          = state_q;
    mem_io.mem_req   = 1'b0;
    mem_io.mem_we    = 1'b0;
    mem_io.iord      = 1'b0;
    ir_write_o       = 1'b0;
    pc_write_o       = 1'b0;
    pc_source_o      = 2'b00;
    reg_write_o      = 1'b0;
    reg_dst_o        = 2'b00;
    mem_to_reg_o     = 2'b00;
    alu_src_a_o      = 1'b0;
    alu_src_b_o      = 2'b00;
    alu_op_o         = 3'b000;
    illegal_o        = 1'b0;

    case (state_q)
      StFetch: begin
        mem_io.mem_req = 1'b1;
        alu_src_b_o    = 2'b01;
        if (mem_io.mem_ready) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OpLw, OpSw:           state_d = StMemAddr;
          OpRtype:              state_d = (funct_i == FnJr) ? StJr : StExecR;
          OpAddi, OpSlti, OpOri: state_d = StExecI;
          OpBeq, OpBne:         state_d = StBranch;
          OpJ, OpJal:           state_d = StJump;
          default:              state_d = StTrap;
        endcase
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (opcode_i == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_io.mem_req = 1'b1;
        mem_io.iord    = 1'b1;
        if (mem_io.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'b01;
        state_d      = StFetch;
      end
      StMemWr: begin
        mem_io.mem_req = 1'b1;
        mem_io.mem_we  = 1'b1;
        mem_io.iord    = 1'b1;
        if (mem_io.mem_ready) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
        state_d     = StRWb;
      end
      StRWb: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 2'b01;
        state_d     = StFetch;
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (opcode_i)
          OpSlti:  alu_op_o = 3'b011;
          OpOri:   alu_op_o = 3'b100;
          default: alu_op_o = 3'b000;
        endcase
        state_d = StIWb;
      end
      StIWb: begin
        reg_write_o = 1'b1;
        state_d     = StFetch;
      end
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b001;
        pc_source_o = 2'b01;
        pc_write_o  = ((opcode_i == OpBeq) && zero_i) || ((opcode_i == OpBne) && !zero_i);
        state_d     = StFetch;
      end
      StJump: begin
        pc_source_o = 2'b10;
        pc_write_o  = 1'b1;
        // PC already holds PC+4, which is the jal link value
        if (opcode_i == OpJal) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 2'b10;
          mem_to_reg_o = 2'b10;
        end
        state_d = StFetch;
      end
      StJr: begin
        pc_source_o = 2'b11;
        pc_write_o  = 1'b1;
        state_d     = StFetch;
      end
      StTrap: begin
        illegal_o = 1'b1;
      end
      default: state_d = StTrap;
    endcase

    state_o = state_q;

    // Reset shows FETCH selects with every write/request suppressed
    if (rst_i) begin
      mem_io.mem_req = 1'b0;
      mem_io.mem_we  = 1'b0;
      mem_io.iord    = 1'b0;
      ir_write_o     = 1'b0;
      pc_write_o     = 1'b0;
      pc_source_o    = 2'b00;
      reg_write_o    = 1'b0;
      reg_dst_o      = 2'b00;
      mem_to_reg_o   = 2'b00;
      alu_src_a_o    = 1'b0;
      alu_src_b_o    = 2'b01;
      alu_op_o       = 3'b000;
      illegal_o      = 1'b0;
      state_o        = StFetch;
    end

    cnt_d = cnt_q;
    if ((state_q != StFetch) && (state_d == StFetch)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_cnt_o = cnt_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the MIPS datapath: a state machine that sequences one instruction over 3–5+ cycles, driving the datapath's mux selects, register-file and PC write enables, and a shared instruction/data memory port with a ready handshake. It sits beside the datapath and replaces the single-cycle decoder.

- It receives the opcode and funct fields from the instruction register, plus the ALU zero flag.
- It returns per-cycle control signals and a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- opcode_i  in  6  IR[31:26]
- funct_i  in  6  IR[5:0]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes current request this cycle
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write request (valid with mem_req_o)
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write_o  out  1  load IR
- pc_write_o  out  1  load PC
- pc_source_o  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs
- reg_write_o  out  1  register-file write
- reg_dst_o  out  2  write-register select: 00 = rt, 01 = rd, 10 = r31
- mem_to_reg_o  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b_o  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op_o  out  3  ALU op: 000 = add, 001 = sub, 010 = R-type by funct, 011 = slt, 100 = or zero-extended
- state_o  out  4  current state encoding
- illegal_o  out  1  TRAP state
- instr_cnt_o  out  CNT_W  retired instructions

## Operation
- Supported opcodes: R-type 0x00 (jr = funct 0x08), addi 0x08, slti 0x0A, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03. Any other opcode is illegal.
- Outputs not listed for a state are 0.
- States (state_o encoding) and the signals each drives:
  - 0 FETCH: mem_req=1, iord=0, srcA=0, srcB=01, aluop=000. If mem_ready_i: ir_write=1, pc_write=1, pc_source=00, go to DECODE; otherwise stay.
  - 1 DECODE: srcA=0, srcB=11, aluop=000 (branch target into ALUOut). Next state by opcode:
    - lw/sw → MEM_ADDR
    - R-type with funct 0x08 → JR; other R-type → EXEC_R
    - addi/slti/ori → EXEC_I
    - beq/bne → BRANCH
    - j/jal → JUMP
    - anything else → TRAP
  - 2 MEM_ADDR: srcA=1, srcB=10, aluop=000. Next: lw → MEM_RD, sw → MEM_WR.
  - 3 MEM_RD: mem_req=1, iord=1. Wait for mem_ready_i, then MEM_WB.
  - 4 MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 → FETCH.
  - 5 MEM_WR: mem_req=1, mem_we=1, iord=1. Wait for mem_ready_i, then FETCH.
  - 6 EXEC_R: srcA=1, srcB=00, aluop=010 → R_WB.
  - 7 R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 → FETCH.
  - 8 EXEC_I: srcA=1, srcB=10, aluop = 000 (addi), 011 (slti) or 100 (ori) → I_WB.
  - 9 I_WB: reg_write=1, reg_dst=00, mem_to_reg=00 → FETCH.
  - 10 BRANCH: srcA=1, srcB=00, aluop=001, pc_source=01. pc_write = (beq & zero_i) | (bne & ~zero_i). → FETCH.
  - 11 JUMP: pc_source=10, pc_write=1. If jal: reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4). → FETCH.
  - 12 JR: pc_source=11, pc_write=1 → FETCH.
  - 13 TRAP: illegal_o=1, all enables 0. Stays until rst_i.
- Unused encodings 14–15 go to TRAP on the next edge.
- Retire: instr_cnt_o increments by 1 on every transition from a non-FETCH state to FETCH. It wraps modulo 2^CNT_W.
- opcode_i and funct_i are held stable by the IR from DECODE until the return to FETCH.

## Timing
- The state register updates on clk_i rising edge. Outputs are combinational from state, except:
  - FETCH ir_write/pc_write are gated by mem_ready_i.
  - BRANCH pc_write is gated by zero_i.
- Reset: rst_i high at an edge forces state=FETCH and instr_cnt_o=0. While rst_i is high, mem_req, mem_we, ir_write, pc_write and reg_write are forced 0 combinationally. All other outputs take their FETCH values; illegal_o=0.
- Reset mid-instruction abandons the instruction with no retire count.
- Reset takes priority over mem_ready_i and over the TRAP hold.
- Zero-wait memory (mem_ready_i high in the same cycle as mem_req_o) gives these CPIs:
  - R-type / addi / slti / ori: 4
  - lw: 5
  - sw: 4
  - beq / bne / j / jal / jr: 3
- Each cycle with mem_req_o=1 and mem_ready_i=0 adds one cycle. All outputs stay constant during the wait.
- mem_ready_i is ignored in states without mem_req_o.

## Test plan
- Reset, then R-type add (0x00 / 0x20) with mem_ready_i=1:
  - state_o sequence 0,1,6,7,0
  - reg_write_o=1 with reg_dst_o=01 only in state 7
  - instr_cnt_o = 1
- lw with 2 wait cycles in FETCH and 1 in MEM_RD:
  - 8 cycles total
  - ir_write_o pulses once, mem_req_o stays high through the waits
  - mem_to_reg_o=01 in MEM_WB
- beq with zero_i=0, then beq with zero_i=1:
  - pc_write_o=0 in state 10 for the first, 1 for the second
  - bne with zero_i=0 gives pc_write_o=1
- jal:
  - state 11 drives pc_source_o=10, reg_dst_o=10, mem_to_reg_o=10, reg_write_o=1
  - jr (funct 0x08) visits state 12 with pc_source_o=11
- Opcode 0x3F:
  - DECODE → TRAP, illegal_o=1 held for 10 cycles, count unchanged
  - rst_i for 1 cycle returns state_o=0, illegal_o=0, instr_cnt_o=0
- Assert rst_i during MEM_WR while waiting on memory:
  - next cycle state_o=0, mem_we_o=0
  - instr_cnt_o=0, no register or PC writes during reset
